// File: rtl/sigplayer.sv
// sigplayer: record-then-playback sample buffer.
//
// RECORD captures mic samples (on en strobes) into an internal RAM; PLAY
// streams the captured burst back out over a valid/ready handshake, either
// once (ending with a one-cycle done pulse) or looped.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   en                 sample strobe while recording
//   rec, play          level requests (rec wins when both are raised in IDLE)
//   loop               1 = wrap to sample 0 after the last sample
//   mic_signal         sample to record
//   out_ready          consumer ready
//   out_valid          out_sample holds a valid sample
//   out_sample         playback sample
//   rec_len            number of samples in the last recording (0..DEPTH)
//   current_address    write pointer (RECORD), presented read pointer (PLAY), else 0
//   busy               RECORD, PLAY or PLAY_END
//   done               one-cycle pulse at the end of a single-pass playback
module sigplayer #(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               rec,
    input  logic               play,
    input  logic               loop,
    input  logic [D_WIDTH-1:0] mic_signal,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [D_WIDTH-1:0] out_sample,
    output logic [A_WIDTH:0]   rec_len,
    output logic [A_WIDTH-1:0] current_address,
    output logic               busy,
    output logic               done
);

    localparam int DEPTH = 2**A_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RECORD, S_PLAY, S_PLAY_END} state_t;

    state_t             r_state, w_state_nxt;
    logic [D_WIDTH-1:0] r_mem [DEPTH];
    logic [D_WIDTH-1:0] r_q;
    logic [D_WIDTH-1:0] r_out_sample;
    logic [A_WIDTH-1:0] r_wr_ptr;
    logic [A_WIDTH:0]   r_rec_len;
    logic [A_WIDTH-1:0] r_iss_ptr;   // next RAM address to read (read-ahead)
    logic [A_WIDTH-1:0] r_addr1;     // address of the sample in r_q
    logic [A_WIDTH-1:0] r_addr2;     // address of the presented sample
    logic [2:1]         r_vld_pipe;  // [1]: r_q valid, [2]: out_sample valid
    logic               r_rec_hold;  // rec still held after a full-buffer stop

    logic               w_wr, w_full, w_adv, w_accept, w_last, w_rd_en;
    logic [A_WIDTH-1:0] w_last_addr;

    assign w_wr        = (r_state == S_RECORD) && en;
    assign w_full      = w_wr && (&r_wr_ptr);
    assign w_last_addr = A_WIDTH'(r_rec_len - 1'b1);
    // The whole read pipeline stalls only while a presented sample waits.
    assign w_adv       = !r_vld_pipe[2] || out_ready;
    assign w_accept    = (r_state == S_PLAY) && r_vld_pipe[2] && out_ready;
    assign w_last      = w_accept && (r_addr2 == w_last_addr);
    assign w_rd_en     = (r_state == S_PLAY) && w_adv;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (rec && !r_rec_hold)
                    w_state_nxt = S_RECORD;
                else if (play && (r_rec_len != '0))
                    w_state_nxt = S_PLAY;
            end
            S_RECORD:   if (w_full || !rec) w_state_nxt = S_IDLE;
            S_PLAY: begin
                if (!play)
                    w_state_nxt = S_IDLE;
                else if (w_last && !loop)
                    w_state_nxt = S_PLAY_END;
            end
            S_PLAY_END: w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // RAM: one write port, registered read port, no reset.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= mic_signal;
        if (w_rd_en)
            r_q <= r_mem[r_iss_ptr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rec_len    <= '0;
            r_iss_ptr    <= '0;
            r_addr1      <= '0;
            r_addr2      <= '0;
            r_vld_pipe   <= '0;
            r_out_sample <= '0;
            r_rec_hold   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // A full-buffer stop must not restart recording while rec stays high.
            if (w_full && rec)
                r_rec_hold <= 1'b1;
            else if (!rec)
                r_rec_hold <= 1'b0;

            if (r_state == S_IDLE && w_state_nxt == S_RECORD) begin
                r_wr_ptr  <= '0;
                r_rec_len <= '0;
            end else if (w_wr) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_rec_len <= r_rec_len + 1'b1;
            end

            // Pipeline is flushed on any cycle not continuing in PLAY, so each
            // entry starts reading from address 0 with nothing in flight.
            // The wrap to 0 is issued speculatively; loop=0 on the last accept
            // leaves PLAY and discards it.
            if (w_state_nxt != S_PLAY) begin
                r_vld_pipe <= '0;
                r_iss_ptr  <= '0;
                r_addr1    <= '0;
                r_addr2    <= '0;
            end else if (w_rd_en) begin
                r_vld_pipe <= {r_vld_pipe[1], 1'b1};
                r_addr1    <= r_iss_ptr;
                r_addr2    <= r_addr1;
                r_iss_ptr  <= (r_iss_ptr == w_last_addr) ? '0 : r_iss_ptr + 1'b1;
                if (r_vld_pipe[1])
                    r_out_sample <= r_q;
            end
        end
    end

    always_comb begin
        current_address = '0;
        case (r_state)
            S_RECORD: current_address = r_wr_ptr;
            S_PLAY:   current_address = r_addr2;
            default:  current_address = '0;
        endcase
    end

    assign out_valid  = r_vld_pipe[2];
    assign out_sample = r_out_sample;
    assign rec_len    = r_rec_len;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_PLAY_END);

endmodule
